// File: rtl/tile_plotter.sv
// Rasterises one Othello cell (empty, cursor box, white or black disk) into
// per-pixel VGA framebuffer writes, one pixel per clock in raster order.
module tile_plotter #(
    parameter int unsigned TILE     = 12,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned DISK_R2  = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_plot,
    input  logic [6:0] y_plot,
    input  logic [1:0] select,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    localparam logic [3:0]        LAST   = 4'(TILE - 1);
    localparam logic signed [5:0] CTR    = 6'(TILE - 1);
    localparam logic [8:0]        SW     = 9'(SCREEN_W);
    localparam logic [7:0]        SH     = 8'(SCREEN_H);
    localparam logic signed [11:0] R2    = 12'(DISK_R2);
    localparam logic [2:0]        GREEN  = 3'b010;
    localparam logic [2:0]        YELLOW = 3'b110;
    localparam logic [2:0]        WHITE  = 3'b111;
    localparam logic [2:0]        BLACK  = 3'b000;

    state_t state, state_next;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [1:0] sel;
    logic [3:0] dx, dy;

    logic [8:0]         sum_x;
    logic [7:0]         sum_y;
    logic signed [5:0]  ox, oy;
    logic signed [11:0] oxw, oyw, r2;
    logic               in_disk, border, on_screen, pix_on, pix_plot, scan_last;
    logic [2:0]         pix_colour;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = DRAW;
            DRAW:  if (scan_last) state_next = FLUSH;
            FLUSH: state_next = DONE;
            DONE:  state_next = IDLE;
        endcase
    end

    // Pixel for the current (dx,dy); offsets are doubled so the disk centre
    // falls on a half-pixel without fractional arithmetic.
    always_comb begin
        sum_x      = {1'b0, base_x} + {5'b0, dx};
        sum_y      = {1'b0, base_y} + {4'b0, dy};
        ox         = $signed({1'b0, dx, 1'b0}) - CTR;
        oy         = $signed({1'b0, dy, 1'b0}) - CTR;
        oxw        = $signed({{6{ox[5]}}, ox});
        oyw        = $signed({{6{oy[5]}}, oy});
        r2         = oxw * oxw + oyw * oyw;
        in_disk    = (r2 <= R2);
        border     = (dx == 4'd0) || (dx == LAST) || (dy == 4'd0) || (dy == LAST);
        on_screen  = (sum_x < SW) && (sum_y < SH);
        scan_last  = (dx == LAST) && (dy == LAST);
        busy       = (state != IDLE);
        pix_colour = GREEN;
        pix_on     = 1'b1;
        unique case (sel)
            2'd0: ;
            2'd1: begin
                pix_colour = YELLOW;
                pix_on     = border;
            end
            2'd2: if (in_disk) pix_colour = WHITE;
            2'd3: if (in_disk) pix_colour = BLACK;
        endcase
        pix_plot = pix_on && on_screen;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_x     <= '0;
            base_y     <= '0;
            sel        <= '0;
            dx         <= '0;
            dy         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    base_x <= x_plot;
                    base_y <= y_plot;
                    sel    <= select;
                    dx     <= '0;
                    dy     <= '0;
                end
                DRAW: begin
                    vga_x      <= sum_x[7:0];
                    vga_y      <= sum_y[6:0];
                    vga_colour <= pix_colour;
                    vga_plot   <= pix_plot;
                    if (dx == LAST) begin
                        dx <= '0;
                        dy <= dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end
                FLUSH: begin
                    vga_plot <= 1'b0;
                    done     <= 1'b1;
                end
                DONE: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_plotter.sv
// Bench for tile_plotter: per-cycle capture of each cell draw compared against
// an arithmetic model of the glyph rules, plus targeted scenario checks.
module tb_tile_plotter;

    logic       clk = 1'b0;
    logic       resetn, start;
    logic [7:0] x_plot;
    logic [6:0] y_plot;
    logic [1:0] select;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    int unsigned passed = 0;
    int unsigned total  = 0;

    localparam int NS = 151;
    logic [7:0] cx[NS];
    logic [6:0] cy[NS];
    logic [2:0] cc[NS];
    logic       cp[NS], cb[NS], cd[NS];

    always #5 clk = ~clk;

    tile_plotter #(.TILE(12), .SCREEN_W(160), .SCREEN_H(120), .DISK_R2(100)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_plot(x_plot), .y_plot(y_plot), .select(select),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Expected write for pixel index n of a cell at (bx,by) with glyph s.
    function automatic void model(input int bx, input int by, input int s, input int n,
                                  output logic [7:0] ex, output logic [6:0] ey,
                                  output logic ep, output logic [2:0] ec);
        int dx, dy, px, py, ox, oy;
        bit disk, bord;
        dx = n % 12;
        dy = n / 12;
        px = bx + dx;
        py = by + dy;
        ox = 2 * dx - 11;
        oy = 2 * dy - 11;
        disk = (ox * ox + oy * oy) <= 100;
        bord = (dx == 0) || (dx == 11) || (dy == 0) || (dy == 11);
        ex = 8'(px);
        ey = 7'(py);
        case (s)
            0:       ec = 3'b010;
            1:       ec = 3'b110;
            2:       ec = disk ? 3'b111 : 3'b010;
            default: ec = disk ? 3'b000 : 3'b010;
        endcase
        ep = (px < 160) && (py < 120) && (s != 1 || bord);
    endfunction

    function automatic int count_writes();
        int c = 0;
        for (int k = 1; k <= 144; k++) if (cp[k] === 1'b1) c++;
        return c;
    endfunction

    // Pulses start, then records outputs #1 after edges T..T+n_samples.
    // inj_k raises a second start (with different inputs) right after sample inj_k.
    task automatic run_cell(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                            input int n_samples, input int inj_k);
        @(negedge clk);
        x_plot = x; y_plot = y; select = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_plot = 8'($urandom); y_plot = 7'($urandom); select = 2'($urandom);
        cx[0] = vga_x; cy[0] = vga_y; cc[0] = vga_colour;
        cp[0] = vga_plot; cb[0] = busy; cd[0] = done;
        for (int k = 1; k <= n_samples; k++) begin
            @(posedge clk);
            #1;
            cx[k] = vga_x; cy[k] = vga_y; cc[k] = vga_colour;
            cp[k] = vga_plot; cb[k] = busy; cd[k] = done;
            start = (k == inj_k);
            if (k == inj_k) begin
                x_plot = 8'd200; y_plot = 7'd100; select = 2'd1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_cell_stream(input int bx, input int by, input int s,
                                    input int n_samples, input int inj_k);
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ep;
        logic [2:0] ec;
        run_cell(8'(bx), 7'(by), 2'(s), n_samples, inj_k);
        for (int k = 0; k <= n_samples; k++) begin
            total++;
            if (cb[k] !== (k <= 145)) $display("FAIL busy k=%0d got %b want %b", k, cb[k], (k <= 145));
            else passed++;
            total++;
            if (cd[k] !== (k == 145)) $display("FAIL done k=%0d got %b want %b", k, cd[k], (k == 145));
            else passed++;
        end
        for (int n = 0; n < 144; n++) begin
            model(bx, by, s, n, ex, ey, ep, ec);
            total++;
            if (cp[n+1] !== ep || cx[n+1] !== ex || cy[n+1] !== ey || (ep && cc[n+1] !== ec))
                $display("FAIL pixel n=%0d cell(%0d,%0d,%0d) got plot=%b x=%0d y=%0d c=%b want plot=%b x=%0d y=%0d c=%b",
                         n, bx, by, s, cp[n+1], cx[n+1], cy[n+1], cc[n+1], ep, ex, ey, ec);
            else passed++;
        end
        for (int k = 145; k <= n_samples; k++) begin
            total++;
            if (cp[k] !== 1'b0) $display("FAIL plot_after k=%0d got %b want 0", k, cp[k]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; x_plot = '0; y_plot = '0; select = '0;
        #12;
        total++; if (vga_x !== 8'd0)      $display("FAIL rst_vga_x got %0d want 0", vga_x); else passed++;
        total++; if (vga_y !== 7'd0)      $display("FAIL rst_vga_y got %0d want 0", vga_y); else passed++;
        total++; if (vga_colour !== 3'd0) $display("FAIL rst_colour got %b want 000", vga_colour); else passed++;
        total++; if (vga_plot !== 1'b0)   $display("FAIL rst_plot got %b want 0", vga_plot); else passed++;
        total++; if (busy !== 1'b0)       $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0)       $display("FAIL rst_done got %b want 0", done); else passed++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        test_cell_stream(9, 9, 0, 150, -1);
        total++; if (count_writes() != 144) $display("FAIL fill_writes got %0d want 144", count_writes()); else passed++;
        total++; if (cx[1] !== 8'd9 || cy[1] !== 7'd9)
            $display("FAIL fill_first got (%0d,%0d) want (9,9)", cx[1], cy[1]); else passed++;
        total++; if (cx[144] !== 8'd20 || cy[144] !== 7'd20)
            $display("FAIL fill_last got (%0d,%0d) want (20,20)", cx[144], cy[144]); else passed++;
    endtask

    task automatic test_cursor();
        bit hit = 0;
        test_cell_stream(22, 35, 1, 150, -1);
        total++; if (count_writes() != 44) $display("FAIL cursor_writes got %0d want 44", count_writes()); else passed++;
        for (int k = 1; k <= 144; k++) if (cp[k] === 1'b1 && cx[k] == 8'd27 && cy[k] == 7'd40) hit = 1;
        total++; if (hit) $display("FAIL cursor_interior got write at (27,40) want none"); else passed++;
    endtask

    task automatic test_disk();
        int whites = 0, want_whites = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ep;
        logic [2:0] ec;
        test_cell_stream(9, 9, 2, 150, -1);
        total++; if (cc[66] !== 3'b111 || cp[66] !== 1'b1) $display("FAIL disk_14_14 got %b want 111", cc[66]); else passed++;
        total++; if (cc[1]  !== 3'b010 || cp[1]  !== 1'b1) $display("FAIL disk_9_9 got %b want 010", cc[1]); else passed++;
        total++; if (cc[6]  !== 3'b010 || cp[6]  !== 1'b1) $display("FAIL disk_14_9 got %b want 010", cc[6]); else passed++;
        total++; if (cc[61] !== 3'b010 || cp[61] !== 1'b1) $display("FAIL disk_9_14 got %b want 010", cc[61]); else passed++;
        total++; if (cc[62] !== 3'b111 || cp[62] !== 1'b1) $display("FAIL disk_10_14 got %b want 111", cc[62]); else passed++;
        for (int n = 0; n < 144; n++) begin
            model(9, 9, 2, n, ex, ey, ep, ec);
            if (ep && ec == 3'b111) want_whites++;
            if (cp[n+1] === 1'b1 && cc[n+1] === 3'b111) whites++;
        end
        total++; if (whites != want_whites) $display("FAIL disk_whites got %0d want %0d", whites, want_whites); else passed++;
    endtask

    task automatic test_clip();
        test_cell_stream(152, 113, 3, 150, -1);
        total++; if (count_writes() != 56) $display("FAIL clip_writes got %0d want 56", count_writes()); else passed++;
    endtask

    task automatic test_back_to_back();
        test_cell_stream(40, 20, 2, 146, 49);
        test_cell_stream(60, 50, 3, 150, -1);
    endtask

    task automatic test_reset_abort();
        bit done_seen = 0, busy_seen = 0;
        run_cell(8'd30, 7'd30, 2'd0, 69, -1);
        total++; if (cp[69] !== 1'b1 || cb[69] !== 1'b1)
            $display("FAIL abort_pre got plot=%b busy=%b want 1 1", cp[69], cb[69]); else passed++;
        #2 resetn = 1'b0;
        #1;
        total++; if (vga_plot !== 1'b0) $display("FAIL abort_plot got %b want 0", vga_plot); else passed++;
        total++; if (busy !== 1'b0)     $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0)     $display("FAIL abort_done got %b want 0", done); else passed++;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1;
            if (busy) busy_seen = 1;
        end
        total++; if (done_seen) $display("FAIL abort_no_done got pulse want none"); else passed++;
        total++; if (busy_seen) $display("FAIL abort_idle got busy want idle"); else passed++;
        test_cell_stream(30, 30, 0, 150, -1);
        total++; if (count_writes() != 144) $display("FAIL abort_redraw got %0d want 144", count_writes()); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            test_cell_stream(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                             int'($urandom_range(0, 3)), 150, -1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_cursor();
        test_disk();
        test_clip();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tile_plotter.md
Name: tile_plotter

Overview:
- Consumer of the board datapath's plot command (x_plot, y_plot, select).
- Rasterises one 12x12 Othello cell into per-pixel writes for the 160x120 VGA adapter framebuffer, one pixel per clock.
- Draws one of four glyphs: empty cell, cursor box, white disk or black disk.
- Sits between the board datapath and the VGA adapter; the control FSM pulses start after each plot command.

Parameters:
TILE, 12, cell edge in pixels (grid pitch 13 leaves 1-pixel grid line)
SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are suppressed
SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are suppressed
DISK_R2, 100, disk threshold in doubled-offset units (see Behaviour)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to draw a cell; sampled only in IDLE
x_plot  input  8  cell origin x (top-left pixel)
y_plot  input  7  cell origin y (top-left pixel)
select  input  2  glyph: 0 empty, 1 cursor box, 2 white disk, 3 black disk
vga_x  output  8  pixel x to adapter
vga_y  output  7  pixel y to adapter
vga_colour  output  3  pixel colour {R,G,B}
vga_plot  output  1  write enable for the current pixel
busy  output  1  high from start acceptance until return to IDLE
done  output  1  one-cycle pulse when the cell is complete

Behaviour:
- Reset (async, resetn=0): state IDLE; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0; counters dx=dy=0; latched inputs cleared.
- Reset mid-draw aborts immediately. No done pulse is issued. After release, the block is in IDLE.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE: on start=1 at edge T, latch x_plot/y_plot/select into base_x/base_y/sel, clear dx=dy=0, go to DRAW, and set busy=1 from T.
- start is ignored in every state other than IDLE; no queuing.
- Input changes after T have no effect on the draw in progress.
- DRAW: each edge registers the pixel for the current (dx,dy) onto the vga_* outputs, then advances the scan.
  - Scan is raster order: dx 0..TILE-1 is the inner loop, dy is the outer loop.
  - After registering (TILE-1,TILE-1), go to FLUSH.
- Output timing: pixel n (n = dy*TILE+dx, 0..143) is valid on the outputs during the cycle following edge T+1+n.
- FLUSH: one edge. Sets vga_plot=0, sets done=1, goes to DONE.
- DONE: done is high for exactly this one cycle. Next edge clears done and busy and returns to IDLE.
- Total: busy high for 146 cycles. Back-to-back start is accepted no earlier than the edge after busy falls.
- Pixel coordinates: vga_x = base_x+dx and vga_y = base_y+dy, computed at full width with 8/7-bit truncation.
  - vga_plot is forced to 0 whenever the untruncated sum is >= SCREEN_W or >= SCREEN_H (clipping, no wrap-around writes).
- Disk mask: ox = 2*dx-(TILE-1), oy = 2*dy-(TILE-1), signed. in_disk = ox^2+oy^2 <= DISK_R2.
- Border mask: dx==0, dx==TILE-1, dy==0 or dy==TILE-1.
- Glyph rules (colours: green 3'b010, yellow 3'b110, white 3'b111, black 3'b000):
  - sel 0: every pixel written green.
  - sel 1: border pixels written yellow; interior pixels have vga_plot=0, so existing disk content is preserved. Coordinates still advance.
  - sel 2: in_disk pixels white, others green; all pixels written.
  - sel 3: in_disk pixels black, others green; all pixels written.
- The pixel count is the same (144) for every select value, so timing is glyph-independent.

Test Plan:
- Reset then start with x_plot=9, y_plot=9, select=0 -> 144 writes covering x 9..20, y 9..20, all colour 3'b010, in raster order. First write is (9,9) the cycle after T+1. done pulses once at cycle T+146. busy is high for 146 cycles.
- select=1 at origin (22,35) -> exactly 44 writes, all 3'b110, all on the border. No writes to interior pixels, e.g. (27,40) never has vga_plot=1.
- select=2 at origin (9,9) -> pixel (14,14) written 3'b111 (ox=oy=-1). Pixel (9,9) written 3'b010 (ox=oy=-11, 242>100). Pixel (14,9) written 3'b010 (ox=-1, oy=-11, 122>100). Pixel (9,14) written 3'b010 (ox=-11, oy=-1, 122>100). Pixel (10,14) written 3'b111 (ox=-9, oy=-1, 82<=100). White count equals the bench model count for DISK_R2=100.
- select=3 at origin (152,113) -> only pixels with x<=159 and y<=119 are written (8x7 = 56 writes); the rest are suppressed. Disk pixels are 3'b000. done still arrives at T+146.
- Second start pulsed mid-draw (cycle T+50) with different inputs -> ignored; the original cell completes unchanged. A start one cycle after busy falls is accepted.
- resetn asserted at cycle T+70 -> vga_plot, busy and done go to 0 immediately with no done pulse. A new start after release draws a full 144-pixel cell.
